// File: rtl/bcd_scan_counter.sv
// N-digit BCD up/down/hold/load counter advanced by a programmable prescaler tick,
// with a time-multiplexed 7-segment driver (one-hot digit enable, active-high segments).
// Latency: value/tick/wrap change 1 cycle after the prescaler match; digit_en/segments are registered (1 cycle).
// Backpressure: none; ena low freezes every register and forces tick/wrap low.
module bcd_scan_counter #(
  parameter int          NUM_DIGITS = 4,
  parameter logic [23:0] MAX_COUNT  = 24'd10_000_000,
  parameter logic [15:0] SCAN_DIV   = 16'd10_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [7:0]              tick_sel,
  input  logic [1:0]              mode,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    wrap,
  output logic                    tick,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              segments
);

  localparam int              VW        = 4 * NUM_DIGITS;
  localparam int              IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [15:0]     SCAN_LAST = SCAN_DIV - 16'd1;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Prescaler state
  logic [23:0] presc_q, presc_d;
  logic [23:0] compare;
  logic        presc_hit;
  logic        tick_q, tick_d;

  // Count state
  logic [VW-1:0] value_q, value_d;
  logic          wrap_q, wrap_d;
  logic [VW-1:0] inc_val, dec_val, load_sat;
  logic          inc_carry, dec_borrow;

  // Scanner state
  logic [15:0]           scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic [6:0]            seg_q, seg_d;
  logic [3:0]            scan_nib;

  // Prescaler compare select and next count; a compare below the current count hits at once
  always_comb begin
    compare   = (tick_sel == 8'd0) ? MAX_COUNT : {6'b0, tick_sel, 10'b0};
    presc_hit = (presc_q >= compare);
    presc_d   = presc_hit ? 24'd0 : presc_q + 24'd1;
    tick_d    = presc_hit;
  end

  // BCD increment with ripple carry; carry out of the top digit means all digits were 9
  always_comb begin
    inc_val   = value_q;
    inc_carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (inc_carry) begin
        if (value_q[4*i +: 4] >= 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
    end
  end

  // BCD decrement with ripple borrow; borrow out of the top digit means all digits were 0
  always_comb begin
    dec_val    = value_q;
    dec_borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dec_borrow) begin
        if (value_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = value_q[4*i +: 4] - 4'd1;
          dec_borrow        = 1'b0;
        end
      end
    end
  end

  // Load data saturated per digit so the count never holds a non-BCD nibble
  always_comb begin
    load_sat = load_value;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_value[4*i +: 4] > 4'd9) begin
        load_sat[4*i +: 4] = 4'd9;
      end
    end
  end

  // Count next-state: clear beats load, load beats the tick-driven count
  always_comb begin
    value_d = value_q;
    wrap_d  = 1'b0;
    if (clear) begin
      value_d = '0;
    end else if (mode == MODE_LOAD) begin
      value_d = load_sat;
    end else if (presc_hit && (mode == MODE_UP)) begin
      value_d = inc_val;
      wrap_d  = inc_carry;
    end else if (presc_hit && (mode == MODE_DOWN)) begin
      value_d = dec_val;
      wrap_d  = dec_borrow;
    end
  end

  // Scanner next-state: dwell SCAN_DIV cycles per digit, then advance modulo NUM_DIGITS
  always_comb begin
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q >= SCAN_LAST) begin
      scan_cnt_d = 16'd0;
      scan_idx_d = (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + IDX_W'(1);
    end else begin
      scan_cnt_d = scan_cnt_q + 16'd1;
    end
  end

  // Digit enable and nibble select for the digit currently being scanned
  always_comb begin
    digit_en_d = '0;
    scan_nib   = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx_q == IDX_W'(i)) begin
        digit_en_d[i] = 1'b1;
        scan_nib      = value_q[4*i +: 4];
      end
    end
  end

  // 7-segment decode, bit0=a .. bit6=g; non-BCD nibbles blank the digit
  always_comb begin
    case (scan_nib)
      4'd0:    seg_d = 7'h3F;
      4'd1:    seg_d = 7'h06;
      4'd2:    seg_d = 7'h5B;
      4'd3:    seg_d = 7'h4F;
      4'd4:    seg_d = 7'h66;
      4'd5:    seg_d = 7'h6D;
      4'd6:    seg_d = 7'h7D;
      4'd7:    seg_d = 7'h07;
      4'd8:    seg_d = 7'h7F;
      4'd9:    seg_d = 7'h6F;
      default: seg_d = 7'h00;
    endcase
  end

  // Prescaler and tick registers; tick_q is cleared while disabled so no stale pulse reappears on re-enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= 24'd0;
      tick_q  <= 1'b0;
    end else if (ena) begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end else begin
      tick_q  <= 1'b0;
    end
  end

  // Count and wrap registers; wrap_q cleared while disabled for the same reason as tick_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
    end else if (ena) begin
      value_q <= value_d;
      wrap_q  <= wrap_d;
    end else begin
      wrap_q  <= 1'b0;
    end
  end

  // Scanner and display registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= 16'd0;
      scan_idx_q <= '0;
      digit_en_q <= '0;
      seg_q      <= 7'h00;
    end else if (ena) begin
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      digit_en_q <= digit_en_d;
      seg_q      <= seg_d;
    end
  end

  // Pulses are forced low combinationally the moment ena drops
  assign value    = value_q;
  assign tick     = tick_q & ena;
  assign wrap     = wrap_q & ena;
  assign digit_en = digit_en_q;
  assign segments = seg_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench: driver applies random/directed stimulus at negedge and queues the
// reference model's expected outputs; a monitor pops and compares after every posedge.
module tb_bcd_scan_counter;

  localparam int ND   = 4;
  localparam int MAXC = 3;
  localparam int SD   = 2;
  localparam int LIM  = 10000;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [7:0]  tick_sel;
  logic [1:0]  mode;
  logic [15:0] load_value;
  logic        clear;
  logic [15:0] value;
  logic        wrap;
  logic        tick;
  logic [3:0]  digit_en;
  logic [6:0]  segments;

  bcd_scan_counter #(
    .NUM_DIGITS(ND),
    .MAX_COUNT (24'd3),
    .SCAN_DIV  (16'd2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .tick_sel  (tick_sel),
    .mode      (mode),
    .load_value(load_value),
    .clear     (clear),
    .value     (value),
    .wrap      (wrap),
    .tick      (tick),
    .digit_en  (digit_en),
    .segments  (segments)
  );

  typedef struct {
    logic [15:0] value;
    logic        wrap;
    logic        tick;
    logic [3:0]  den;
    logic [6:0]  seg;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: count as a plain integer, scan position as enabled-cycle count
  int         m_presc = 0;
  int         m_val   = 0;
  int         m_k     = 0;
  logic [3:0] m_den   = 4'd0;
  logic [6:0] m_seg   = 7'd0;
  logic       m_tick  = 1'b0;
  logic       m_wrap  = 1'b0;

  logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int         P10 [4]  = '{1, 10, 100, 1000};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] ld);
    int v;
    int d;
    v = 0;
    for (int i = 0; i < ND; i++) begin
      d = int'(ld[4*i +: 4]);
      if (d > 9) d = 9;
      v = v + d * P10[i];
    end
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven, queue expectation
  task automatic model_step();
    exp_t e;
    int   cmp;
    int   idx;
    bit   hit;
    if (ena) begin
      cmp     = (tick_sel == 8'd0) ? MAXC : int'(tick_sel) * 1024;
      hit     = (m_presc >= cmp);
      idx     = (m_k / SD) % ND;
      m_den   = 4'(1 << idx);
      m_seg   = SEG[(m_val / P10[idx]) % 10];
      m_k     = (m_k + 1) % (SD * ND);
      m_wrap  = 1'b0;
      if (clear) begin
        m_val = 0;
      end else if (mode == 2'b11) begin
        m_val = from_load(load_value);
      end else if (hit && mode == 2'b00) begin
        if (m_val == LIM - 1) begin m_val = 0; m_wrap = 1'b1; end
        else m_val = m_val + 1;
      end else if (hit && mode == 2'b01) begin
        if (m_val == 0) begin m_val = LIM - 1; m_wrap = 1'b1; end
        else m_val = m_val - 1;
      end
      m_presc = hit ? 0 : m_presc + 1;
      m_tick  = hit;
    end else begin
      m_tick = 1'b0;
      m_wrap = 1'b0;
    end
    e.value = to_bcd(m_val);
    e.wrap  = m_wrap;
    e.tick  = m_tick;
    e.den   = m_den;
    e.seg   = m_seg;
    q.push_back(e);
  endtask

  task automatic cyc(input logic e, input logic [1:0] md, input logic [15:0] ld,
                     input logic cl, input logic [7:0] ts);
    @(negedge clk);
    rst_n      = 1'b1;
    ena        = e;
    mode       = md;
    load_value = ld;
    clear      = cl;
    tick_sel   = ts;
    model_step();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_value"},    32'(value),    32'd0);
    chk({tag, "_wrap"},     32'(wrap),     32'd0);
    chk({tag, "_tick"},     32'(tick),     32'd0);
    chk({tag, "_digit_en"}, 32'(digit_en), 32'd0);
    chk({tag, "_segments"}, 32'(segments), 32'd0);
  endtask

  // Monitor: every posedge the DUT presents a new output set; compare against the queue head
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("value",    32'(value),    32'(mon_e.value));
      chk("wrap",     32'(wrap),     32'(mon_e.wrap));
      chk("tick",     32'(tick),     32'(mon_e.tick));
      chk("digit_en", 32'(digit_en), 32'(mon_e.den));
      chk("segments", 32'(segments), 32'(mon_e.seg));
    end
  end

  initial begin
    int r;
    logic [1:0] md;
    rst_n      = 1'b0;
    ena        = 1'b0;
    mode       = 2'b00;
    load_value = 16'h0000;
    clear      = 1'b0;
    tick_sel   = 8'd0;
    #3;
    check_all_zero("reset");

    // Up count from reset, tick every 4 cycles
    repeat (60) cyc(1'b1, 2'b00, 16'h0000, 1'b0, 8'd0);
    // Load near the top then count through the all-nines wrap
    cyc(1'b1, 2'b11, 16'h9998, 1'b0, 8'd0);
    repeat (16) cyc(1'b1, 2'b00, 16'h0000, 1'b0, 8'd0);
    // Borrow across a digit, then underflow wrap from zero
    cyc(1'b1, 2'b11, 16'h0010, 1'b0, 8'd0);
    repeat (12) cyc(1'b1, 2'b01, 16'h0000, 1'b0, 8'd0);
    cyc(1'b1, 2'b11, 16'h0000, 1'b0, 8'd0);
    repeat (8) cyc(1'b1, 2'b01, 16'h0000, 1'b0, 8'd0);
    // Clear beats load on every cycle including tick cycles
    repeat (6) cyc(1'b1, 2'b11, 16'h0042, 1'b1, 8'd0);
    // Saturating load of non-BCD nibbles
    cyc(1'b1, 2'b11, 16'hFAFA, 1'b0, 8'd0);
    repeat (4) cyc(1'b1, 2'b10, 16'h0000, 1'b0, 8'd0);
    // Static 1234 to watch the scan sequence
    cyc(1'b1, 2'b11, 16'h1234, 1'b0, 8'd0);
    repeat (20) cyc(1'b1, 2'b10, 16'h0000, 1'b0, 8'd0);
    // Disabled for 50 cycles with noisy inputs: everything freezes
    cyc(1'b1, 2'b00, 16'h0000, 1'b0, 8'd0);
    repeat (50) cyc(1'b0, 2'($urandom_range(0, 3)), 16'($urandom), 1'($urandom_range(0, 1)), 8'd0);
    repeat (10) cyc(1'b1, 2'b00, 16'h0000, 1'b0, 8'd0);
    // Long prescaler period (1025 cycles), then drop compare below the running count
    repeat (2500) cyc(1'b1, 2'b00, 16'h0000, 1'b0, 8'd1);
    while (m_presc < 10) cyc(1'b1, 2'b00, 16'h0000, 1'b0, 8'd1);
    repeat (10) cyc(1'b1, 2'b00, 16'h0000, 1'b0, 8'd0);
    // Randomised mix of modes, clears, enables and prescaler selects
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 9);
      md = (r < 5) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      cyc(($urandom_range(0, 9) != 0), md, 16'($urandom),
          ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 19) == 0) ? 8'($urandom_range(1, 2)) : 8'd0);
    end
    // Asynchronous reset between clock edges
    repeat (5) cyc(1'b1, 2'b00, 16'h0000, 1'b0, 8'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    m_presc = 0; m_val = 0; m_k = 0; m_den = 4'd0; m_seg = 7'd0; m_tick = 1'b0; m_wrap = 1'b0;
    repeat (20) cyc(1'b1, 2'b00, 16'h0000, 1'b0, 8'd0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
